irrig_tick_ctrl: RTL and testbench

Upstream control stage for the irrigation system's 4-bit JK up/down counter. Generates the counter's single-cycle count tick and its direction (`mode`) from operator buttons, the soil-dryness sensor and the counter value fed back. The counter runs a fill phase (count up to 15) and a drain phase (count down to 0). It repeats while the soil stays dry and stops when it is wet.

---
 rtl/irrig_tick_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_irrig_tick_ctrl.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irrig_tick_ctrl.sv
// -----------------------------------------------------------------------------
// irrig_tick_ctrl
// Control stage in front of the irrigation 4-bit JK up/down counter. It turns
// the operator buttons, the soil-dryness sensor and the counter value fed back
// into a single-cycle count tick and a count direction. One irrigation cycle
// is a fill phase (count up to 15) followed by a drain phase (count down to 0).
// The cycle repeats while the soil stays dry.
//
// Parameters
//   DIV     clk cycles per tick (4..65535)
//   DB_CYC  cycles an input must stay stable to be accepted (debounce build only)
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous reset, active low
//   start  in   start/resume button (asynchronous, active high)
//   stop   in   pause/abort button (asynchronous, active high)
//   dry    in   soil sensor level, 1 = needs water (asynchronous)
//   q      in   [3:0] counter value fed back
//   tick   out  one-clk pulse that advances the counter
//   mode   out  counter direction, 1 = up, 0 = down
//   run    out  1 while the counter is actively counting
//   done   out  one-clk pulse when a fill+drain cycle completes
//
// Build option
//   IRRIG_TICK_CTRL_DEBOUNCE_EN  adds a DB_CYC-cycle stable-level filter after
//                                each input synchronizer.
// -----------------------------------------------------------------------------
module irrig_tick_ctrl #(
    parameter int DIV    = 250,
    parameter int DB_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       dry,
    input  logic [3:0] q,
    output logic       tick,
    output logic       mode,
    output logic       run,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // Elaboration-time guard on the legal parameter ranges.
    if (DIV < 4 || DIV > 65535 || DB_CYC < 1) begin : g_bad_param
        $error("irrig_tick_ctrl: DIV must be 4..65535 and DB_CYC >= 1");
    end

    // ------------------------------------------------------------------------
    // Input conditioning: bit 0 = start, bit 1 = stop, bit 2 = dry
    // ------------------------------------------------------------------------
    logic [2:0] w_raw;
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] w_cond;     // synchronized (and optionally filtered) levels
    logic [1:0] r_prev;     // previous start/stop level for edge detection
    logic       w_start_p;
    logic       w_stop_p;
    logic       w_dry;

    assign w_raw = {dry, stop, start};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the clock edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef IRRIG_TICK_CTRL_DEBOUNCE_EN
    localparam int DB_W = $clog2(DB_CYC + 1);

    logic [DB_W-1:0] r_db_cnt [3];
    logic [2:0]      r_db_lvl;

    // The accepted level only follows the synchronized input after it has
    // differed from the accepted level for DB_CYC consecutive cycles.
    // NOTE: this small counter array is reset element by element; it is
    // control state, not a storage RAM, so a reset is both legal and required.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db_lvl <= '0;
            for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db_lvl[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_W'(DB_CYC - 1)) begin
                    r_db_lvl[i] <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign w_cond = r_db_lvl;
`else
    assign w_cond = r_sync2;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_prev <= '0;
        else      r_prev <= w_cond[1:0];
    end

    assign w_start_p = w_cond[0] & ~r_prev[0];
    assign w_stop_p  = w_cond[1] & ~r_prev[1];
    assign w_dry     = w_cond[2];

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_saved_drain;   // suspended phase while in HOLD: 1 = DRAIN
    logic        w_saved_nxt;
    logic        r_drain_ticked;  // a tick has been issued since DRAIN was entered
    logic [15:0] r_pre;
    logic        w_drain_end;

    // The q==0 seen right after entering DRAIN must not end the phase, so the
    // exit also needs at least one tick issued inside DRAIN.
    assign w_drain_end = (q == 4'd0) && r_drain_ticked;

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_saved_nxt = r_saved_drain;
        run         = 1'b0;
        mode        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_p && !w_stop_p && w_dry) w_state_nxt = S_FILL;
            end
            S_FILL: begin
                run = 1'b1;
                if (w_stop_p) begin
                    // A pending fill->drain change is stored as DRAIN.
                    w_state_nxt = S_HOLD;
                    w_saved_nxt = (q == 4'd15);
                end else if (q == 4'd15) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                run  = 1'b1;
                mode = 1'b0;
                if (w_drain_end) begin
                    // done pulses even when stop arrives in the same cycle.
                    done        = 1'b1;
                    w_state_nxt = (w_stop_p || !w_dry) ? S_IDLE : S_FILL;
                end else if (w_stop_p) begin
                    w_state_nxt = S_HOLD;
                    w_saved_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                mode = ~r_saved_drain;
                if (w_stop_p)       w_state_nxt = S_IDLE;
                else if (w_start_p) w_state_nxt = r_saved_drain ? S_DRAIN : S_FILL;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign tick = run && (r_pre == 16'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_saved_drain  <= 1'b0;
            r_pre          <= '0;
            r_drain_ticked <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_saved_drain <= w_saved_nxt;

            // Prescaler restarts from 0 on each IDLE entry, holds while paused.
            if (w_state_nxt == S_IDLE && r_state != S_IDLE) r_pre <= '0;
            else if (tick)                                 r_pre <= '0;
            else if (run)                                  r_pre <= r_pre + 16'd1;

            // Cleared outside DRAIN/HOLD so a resumed DRAIN keeps its history.
            if (r_state == S_DRAIN && tick)                      r_drain_ticked <= 1'b1;
            else if (r_state == S_FILL || r_state == S_IDLE)     r_drain_ticked <= 1'b0;
        end
    end

endmodule

// File: tb/tb_irrig_tick_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irrig_tick_ctrl
// Bench for irrig_tick_ctrl with DIV=4 and a behavioural JK up/down counter
// closing the q feedback loop. Each tick is matched against a queue of the
// direction expected for it; scenario tasks check timing and state around it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_irrig_tick_ctrl;

    localparam int DIV    = 4;
    localparam int DB_CYC = 16;
`ifdef IRRIG_TICK_CTRL_DEBOUNCE_EN
    localparam int BTN_LAT = 3 + DB_CYC;
`else
    localparam int BTN_LAT = 3;
`endif

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       dry   = 1'b0;
    logic [3:0] q;
    logic       tick;
    logic       mode;
    logic       run;
    logic       done;

    int n_checks   = 0;
    int n_fail     = 0;
    int tick_cnt   = 0;
    int elapsed    = 0;   // run cycles since the last tick (prescaler model)
    int cyc        = 0;
    int last_tick  = -1;
    bit chk_period = 1'b0;
    bit exp_m;
    bit sb[$];            // expected mode for each upcoming tick

    irrig_tick_ctrl #(.DIV(DIV), .DB_CYC(DB_CYC)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .stop (stop),
        .dry  (dry),
        .q    (q),
        .tick (tick),
        .mode (mode),
        .run  (run),
        .done (done)
    );

    always #5 clk = ~clk;

    // 4-bit up/down counter driven by tick/mode
    always @(posedge clk or negedge rst) begin
        if (!rst)      q <= 4'd0;
        else if (tick) q <= mode ? q + 4'd1 : q - 4'd1;
    end

    // Tick monitor / scoreboard
    always @(negedge clk) begin
        cyc++;
        if (rst && tick) begin
            tick_cnt++;
            n_checks++;
            if (run !== 1'b1) begin
                n_fail++;
                $display("FAIL tick_without_run: run=%b required 1", run);
            end
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_tick: unexpected tick at q=%0d mode=%b, none required", q, mode);
            end else begin
                exp_m = sb.pop_front();
                if (mode !== exp_m) begin
                    n_fail++;
                    $display("FAIL sb_mode: tick at q=%0d mode=%b required %b", q, mode, exp_m);
                end
            end
            if (chk_period) begin
                if (last_tick >= 0) begin
                    n_checks++;
                    if (cyc - last_tick != DIV) begin
                        n_fail++;
                        $display("FAIL tick_period: %0d clk required %0d", cyc - last_tick, DIV);
                    end
                end
                last_tick = cyc;
            end
        end
        if (tick)             elapsed = 0;
        else if (rst && run)  elapsed++;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (all return at negedge + 1)
    // ------------------------------------------------------------------------
    task automatic nclk(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic press(input bit b_start, input bit b_stop, output int lat);
        logic r0;
        r0 = run;
        if (b_start) start = 1'b1;
        if (b_stop)  stop  = 1'b1;
        lat = 0;
        while (run === r0 && lat < 80) begin
            nclk(1);
            lat++;
        end
    endtask

    task automatic release_btns();
        nclk(20);
        start = 1'b0;
        stop  = 1'b0;
        nclk(20);
    endtask

    task automatic first_tick(output int k);
        k = 1;
        while (tick !== 1'b1 && k < 40) begin
            nclk(1);
            k++;
        end
    endtask

    task automatic wait_q(input logic [3:0] val, input logic m, input int budget, output bit ok);
        int n = 0;
        while (!(q === val && mode === m) && n < budget) begin
            nclk(1);
            n++;
        end
        ok = (q === val && mode === m);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            nclk(1);
            n++;
        end
        ok = (done === 1'b1);
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        int t0;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            start = 1'($urandom_range(0, 1));
            stop  = 1'($urandom_range(0, 1));
            dry   = 1'($urandom_range(0, 1));
            nclk(1);
            n_checks++;
            if ({tick, mode, run, done} !== 4'b0100) begin
                n_fail++;
                $display("FAIL reset_outputs: tick,mode,run,done=%b required 0100",
                         {tick, mode, run, done});
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        dry   = 1'b1;
        nclk(1);
        rst = 1'b1;
        t0  = tick_cnt;
        nclk(1000);
        n_checks++;
        if (tick_cnt != t0 || run !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: ticks=%0d run=%b required 0 ticks run=0", tick_cnt - t0, run);
        end
    endtask

    task automatic test_full_cycle();
        int lat, k, t0;
        bit ok;
        dry = 1'b1;
        nclk(25);
        repeat (15) sb.push_back(1'b1);
        repeat (15) sb.push_back(1'b0);
        t0 = tick_cnt;
        last_tick = -1;
        chk_period = 1'b1;
        elapsed = 0;
        press(1'b1, 1'b0, lat);
        n_checks++;
        if (lat != BTN_LAT) begin
            n_fail++;
            $display("FAIL start_latency: %0d clk required %0d", lat, BTN_LAT);
        end
        n_checks++;
        if ({mode, q} !== 5'b1_0000) begin
            n_fail++;
            $display("FAIL fill_entry: mode=%b q=%0d required mode=1 q=0", mode, q);
        end
        first_tick(k);
        n_checks++;
        if (k != DIV) begin
            n_fail++;
            $display("FAIL first_tick: %0d clk required %0d", k, DIV);
        end
        release_btns();
        wait_q(4'd15, 1'b1, 200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reach_15: q=%0d mode=%b required q=15 mode=1", q, mode);
        end
        nclk(1);
        n_checks++;
        if (mode !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_fall: mode=%b one clk after q==15, required 0", mode);
        end
        dry = 1'b0;
        wait_done(300, ok);
        n_checks++;
        if (!ok || q !== 4'd0) begin
            n_fail++;
            $display("FAIL done_seen: done=%b q=%0d required done=1 q=0", done, q);
        end
        n_checks++;
        if (tick_cnt - t0 != 30) begin
            n_fail++;
            $display("FAIL tick_total: %0d ticks required 30", tick_cnt - t0);
        end
        nclk(1);
        n_checks++;
        if ({done, run, mode} !== 3'b001) begin
            n_fail++;
            $display("FAIL idle_after_done: done,run,mode=%b required 001", {done, run, mode});
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drained: %0d ticks outstanding required 0", sb.size());
        end
        chk_period = 1'b0;
    endtask

    task automatic test_repeat_pause();
        int lat, k, el, t0;
        bit ok;
        logic [3:0] q_hold;
        dry = 1'b1;
        nclk(25);
        repeat (15) sb.push_back(1'b1);
        repeat (15) sb.push_back(1'b0);
        elapsed = 0;
        press(1'b1, 1'b0, lat);
        release_btns();
        wait_done(300, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL repeat_done: done=%b required 1", done);
        end
        nclk(1);
        n_checks++;
        if ({run, mode, q} !== 6'b11_0000) begin
            n_fail++;
            $display("FAIL refill: run=%b mode=%b q=%0d required run=1 mode=1 q=0", run, mode, q);
        end
        repeat (15) sb.push_back(1'b1);
        repeat (12) sb.push_back(1'b0);
        wait_q(4'd1, 1'b1, 40, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL climb_again: q=%0d mode=%b required q=1 mode=1", q, mode);
        end
        wait_q(4'd9, 1'b0, 300, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reach_9_drain: q=%0d mode=%b required q=9 mode=0", q, mode);
        end
        press(1'b0, 1'b1, lat);
        q_hold = q;
        el     = elapsed;
        n_checks++;
        if (lat != BTN_LAT) begin
            n_fail++;
            $display("FAIL stop_latency: %0d clk required %0d", lat, BTN_LAT);
        end
`ifndef IRRIG_TICK_CTRL_DEBOUNCE_EN
        n_checks++;
        if (q_hold !== 4'd9) begin
            n_fail++;
            $display("FAIL pause_q: q=%0d required 9", q_hold);
        end
`endif
        t0 = tick_cnt;
        release_btns();
        n_checks++;
        if (tick_cnt != t0 || {run, mode} !== 2'b00 || q !== q_hold) begin
            n_fail++;
            $display("FAIL hold_state: ticks=%0d run=%b mode=%b q=%0d required 0 ticks run=0 mode=0 q=%0d",
                     tick_cnt - t0, run, mode, q, q_hold);
        end
        sb.delete();
        sb.push_back(1'b0);
        press(1'b1, 1'b0, lat);
        n_checks++;
        if (lat != BTN_LAT) begin
            n_fail++;
            $display("FAIL resume_latency: %0d clk required %0d", lat, BTN_LAT);
        end
        first_tick(k);
        n_checks++;
        if (k != DIV - el) begin
            n_fail++;
            $display("FAIL resume_tick: %0d clk required %0d", k, DIV - el);
        end
        nclk(1);
        n_checks++;
        if (q !== q_hold - 4'd1 || mode !== 1'b0) begin
            n_fail++;
            $display("FAIL resume_q: q=%0d mode=%b required q=%0d mode=0", q, mode, q_hold - 4'd1);
        end
        // Asynchronous reset in the middle of a running drain
        start = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({tick, mode, run, done} !== 4'b0100) begin
            n_fail++;
            $display("FAIL async_reset: tick,mode,run,done=%b required 0100", {tick, mode, run, done});
        end
        nclk(3);
        sb.delete();
        rst = 1'b1;
        nclk(25);
    endtask

    task automatic test_priority();
        int lat, k, t0;
        dry = 1'b1;
        nclk(25);
        elapsed = 0;
        repeat (15) sb.push_back(1'b1);
        press(1'b1, 1'b0, lat);
        start = 1'b0;
        nclk(22);
        press(1'b1, 1'b1, lat);
        n_checks++;
        if (lat != BTN_LAT || mode !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_hold: latency=%0d mode=%b required latency=%0d mode=1", lat, mode, BTN_LAT);
        end
        t0 = tick_cnt;
        nclk(10);
        release_btns();
        n_checks++;
        if (run !== 1'b0 || tick_cnt != t0) begin
            n_fail++;
            $display("FAIL stop_wins: run=%b ticks=%0d required run=0 0 ticks", run, tick_cnt - t0);
        end
        sb.delete();
        // Second stop moves HOLD to IDLE; start with dry=0 must then be ignored.
        stop = 1'b1;
        nclk(20);
        stop = 1'b0;
        nclk(20);
        dry = 1'b0;
        nclk(25);
        t0 = tick_cnt;
        start = 1'b1;
        nclk(20);
        start = 1'b0;
        nclk(40);
        n_checks++;
        if (run !== 1'b0 || tick_cnt != t0) begin
            n_fail++;
            $display("FAIL start_dry0_ignored: run=%b ticks=%0d required run=0 0 ticks", run, tick_cnt - t0);
        end
        dry = 1'b1;
        nclk(25);
        sb.push_back(1'b1);
        press(1'b1, 1'b0, lat);
        first_tick(k);
        n_checks++;
        if (lat != BTN_LAT || k != DIV) begin
            n_fail++;
            $display("FAIL idle_restart: latency=%0d first tick=%0d required %0d and %0d",
                     lat, k, BTN_LAT, DIV);
        end
        start = 1'b0;
        rst = 1'b0;
        nclk(3);
        sb.delete();
        rst = 1'b1;
        nclk(25);
    endtask

`ifdef IRRIG_TICK_CTRL_DEBOUNCE_EN
    task automatic test_debounce();
        int n;
        dry = 1'b1;
        nclk(25);
        start = 1'b1;
        nclk(10);
        start = 1'b0;
        nclk(40);
        n_checks++;
        if (run !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_rejected: run=%b required 0", run);
        end
        start = 1'b1;
        n = 0;
        while (run !== 1'b1 && n < 60) begin
            nclk(1);
            n++;
        end
        n_checks++;
        if (n != 3 + DB_CYC) begin
            n_fail++;
            $display("FAIL db_press_latency: %0d clk required %0d", n, 3 + DB_CYC);
        end
        nclk(1);
        start = 1'b0;
        rst = 1'b0;
        nclk(2);
        rst = 1'b1;
        nclk(25);
    endtask
`else
    task automatic test_sync_pulse();
        int n;
        dry = 1'b1;
        nclk(25);
        start = 1'b1;
        nclk(1);
        start = 1'b0;
        n = 1;
        while (run !== 1'b1 && n < 60) begin
            nclk(1);
            n++;
        end
        n_checks++;
        if (n != 3) begin
            n_fail++;
            $display("FAIL short_pulse_latency: %0d clk required 3", n);
        end
        rst = 1'b0;
        nclk(2);
        rst = 1'b1;
        nclk(25);
    endtask
`endif

    initial begin
        test_reset();
        test_full_cycle();
        test_repeat_pause();
        test_priority();
`ifdef IRRIG_TICK_CTRL_DEBOUNCE_EN
        test_debounce();
`else
        test_sync_pulse();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
